// File: rtl/dda_step_generator_if.sv
// Move-command handshake between the SPI command FSM (master) and the DDA step generator (slave).
interface dda_step_generator_if #(
    parameter int ACC_W  = 64,
    parameter int TICK_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_dir;
    logic [ACC_W-1:0]  cmd_velocity;
    logic [ACC_W-1:0]  cmd_accel;
    logic [TICK_W-1:0] cmd_ticks;

    modport master (
        output cmd_valid, cmd_dir, cmd_velocity, cmd_accel, cmd_ticks,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_dir, cmd_velocity, cmd_accel, cmd_ticks,
        output cmd_ready
    );
endinterface

// File: rtl/dda_step_generator.sv
// DDA step generator: turns queued (rate, accel, ticks) moves into step/dir/enable,
// with a one-deep command slot so consecutive moves run back-to-back.
module dda_step_generator #(
    parameter int ACC_W             = 64,
    parameter int TICK_W            = 32,
    parameter int STEP_PULSE_CYCLES = 8,
    parameter int DIR_SETUP_CYCLES  = 4
) (
    input  logic                 CLK,
    input  logic                 resetn,
    dda_step_generator_if.slave  cmd,
    input  logic [7:0]           clock_divisor,
    input  logic                 halt,
    output logic                 step,
    output logic                 dir,
    output logic                 enable,
    output logic                 move_done,
    output logic                 step_overrun
);
    localparam int PW = $clog2(STEP_PULSE_CYCLES + 1);
    localparam int SW = $clog2(DIR_SETUP_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SETUP, S_RUN} state_t;

    state_t r_state, w_next;

    logic              r_pend_valid, r_pend_dir;
    logic [ACC_W-1:0]  r_pend_vel, r_pend_accel;
    logic [TICK_W-1:0] r_pend_ticks;

    logic              r_act_dir, r_dir;
    logic [ACC_W-1:0]  r_vel, r_accel, r_acc;
    logic [TICK_W-1:0] r_ticks_left;
    logic [7:0]        r_presc;
    logic [SW-1:0]     r_setup_cnt;
    logic              r_step, r_overrun, r_move_done;
    logic [PW-1:0]     r_pulse_cnt;

    logic              w_accept, w_tick, w_last, w_need_setup, w_setup_done;
    logic              w_load_zero, w_setup_zero, w_done_now, w_carry_tick;
    logic [ACC_W:0]    w_acc_sum;
    logic [ACC_W+1:0]  w_vel_sum;
    logic [ACC_W-1:0]  w_vel_sat;

    assign w_accept     = cmd.cmd_valid && !r_pend_valid && !halt;
    assign w_tick       = (r_state == S_RUN) && (r_presc == clock_divisor) && !halt;
    assign w_last       = w_tick && (r_ticks_left == TICK_W'(1));
    assign w_need_setup = (r_pend_dir != r_dir) || r_step;
    assign w_setup_done = (r_state == S_SETUP) && !r_step && (r_setup_cnt == SW'(1));
    assign w_load_zero  = (r_state == S_LOAD) && !w_need_setup && (r_pend_ticks == '0);
    assign w_setup_zero = w_setup_done && (r_ticks_left == '0);
    assign w_done_now   = !halt && (w_last || w_load_zero || w_setup_zero);

    assign w_acc_sum    = {1'b0, r_acc} + {1'b0, r_vel};
    assign w_carry_tick = w_tick && w_acc_sum[ACC_W];
    // Two guard bits: the top one flags a negative result, the next one overflow past max.
    assign w_vel_sum    = {2'b00, r_vel} + {{2{r_accel[ACC_W-1]}}, r_accel};
    assign w_vel_sat    = w_vel_sum[ACC_W+1] ? '0 :
                          w_vel_sum[ACC_W]   ? '1 : w_vel_sum[ACC_W-1:0];

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (halt) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (r_pend_valid) w_next = S_LOAD;
                S_LOAD: begin
                    if (w_need_setup)             w_next = S_SETUP;
                    else if (r_pend_ticks == '0)  w_next = S_IDLE;
                    else                          w_next = S_RUN;
                end
                S_SETUP: begin
                    if (w_setup_zero)      w_next = r_pend_valid ? S_LOAD : S_IDLE;
                    else if (w_setup_done) w_next = S_RUN;
                end
                S_RUN:   if (w_last) w_next = r_pend_valid ? S_LOAD : S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        enable        = (r_state != S_IDLE) || r_step;
        cmd.cmd_ready = !r_pend_valid;
        step          = r_step;
        dir           = r_dir;
        move_done     = r_move_done;
        step_overrun  = r_overrun;
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            r_pend_valid <= 1'b0;
            r_pend_dir   <= 1'b0;
            r_pend_vel   <= '0;
            r_pend_accel <= '0;
            r_pend_ticks <= '0;
        end else if (halt) begin
            r_pend_valid <= 1'b0;
        end else begin
            if (r_state == S_LOAD) r_pend_valid <= 1'b0;
            if (w_accept) begin
                r_pend_valid <= 1'b1;
                r_pend_dir   <= cmd.cmd_dir;
                r_pend_vel   <= cmd.cmd_velocity;
                r_pend_accel <= cmd.cmd_accel;
                r_pend_ticks <= cmd.cmd_ticks;
            end
        end
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            r_act_dir    <= 1'b0;
            r_dir        <= 1'b0;
            r_vel        <= '0;
            r_accel      <= '0;
            r_acc        <= '0;
            r_ticks_left <= '0;
            r_presc      <= '0;
            r_setup_cnt  <= '0;
            r_move_done  <= 1'b0;
        end else begin
            r_move_done <= w_done_now;
            if (halt) begin
                r_acc <= '0;
            end else begin
                case (r_state)
                    S_LOAD: begin
                        r_act_dir    <= r_pend_dir;
                        r_vel        <= r_pend_vel;
                        r_accel      <= r_pend_accel;
                        r_ticks_left <= r_pend_ticks;
                        r_presc      <= '0;
                        r_setup_cnt  <= SW'(DIR_SETUP_CYCLES);
                    end
                    S_SETUP: begin
                        // The hold count only runs once the previous pulse has dropped.
                        if (!r_step) begin
                            r_dir <= r_act_dir;
                            if (r_setup_cnt != SW'(1)) r_setup_cnt <= r_setup_cnt - SW'(1);
                        end
                    end
                    S_RUN: begin
                        r_presc <= (r_presc == clock_divisor) ? 8'd0 : r_presc + 8'd1;
                        if (w_tick) begin
                            r_acc        <= w_acc_sum[ACC_W-1:0];
                            r_vel        <= w_vel_sat;
                            r_ticks_left <= r_ticks_left - TICK_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            r_step      <= 1'b0;
            r_pulse_cnt <= '0;
            r_overrun   <= 1'b0;
        end else if (r_step) begin
            if (r_pulse_cnt == '0) r_step <= 1'b0;
            else                   r_pulse_cnt <= r_pulse_cnt - PW'(1);
            if (w_carry_tick)      r_overrun <= 1'b1;
        end else if (w_carry_tick) begin
            r_step      <= 1'b1;
            r_pulse_cnt <= PW'(STEP_PULSE_CYCLES - 1);
        end
    end
endmodule

// File: tb/tb_dda_step_generator.sv
// Self-checking bench for dda_step_generator: directed vector table, hand-written corner
// sequences and randomized moves against an arithmetic step-count model.
module tb_dda_step_generator;
    localparam logic [63:0] HALF = 64'h8000_0000_0000_0000;

    logic       CLK = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] clock_divisor = 8'd0;
    logic       halt = 1'b0;
    logic       step, dir, enable, move_done, step_overrun;

    dda_step_generator_if #(.ACC_W(64), .TICK_W(32)) cmd_if ();

    dda_step_generator #(
        .ACC_W(64), .TICK_W(32), .STEP_PULSE_CYCLES(8), .DIR_SETUP_CYCLES(4)
    ) dut (
        .CLK(CLK), .resetn(resetn), .cmd(cmd_if), .clock_divisor(clock_divisor),
        .halt(halt), .step(step), .dir(dir), .enable(enable),
        .move_done(move_done), .step_overrun(step_overrun)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // Output monitor: step count, done count, pulse widths, dir-to-step setup.
    int   n_steps = 0, n_dones = 0, n_setup_viol = 0, n_width_viol = 0;
    int   since_dir = 100, width = 0;
    logic p_step = 1'b0, p_dir = 1'b0;

    always @(negedge CLK) begin
        if (!resetn) begin
            p_step = 1'b0; p_dir = dir; width = 0; since_dir = 100;
        end else begin
            if (dir !== p_dir) begin
                since_dir = 0;
                if (step) n_setup_viol++;
            end else if (since_dir < 100) since_dir++;
            if (step && !p_step) begin
                n_steps++;
                if (since_dir < 4) n_setup_viol++;
            end
            if (step) width++;
            else if (p_step) begin
                if (width != 8) n_width_viol++;
                width = 0;
            end
            if (move_done) n_dones++;
            p_step = step; p_dir = dir;
        end
    end

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    task automatic do_reset();
        halt = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        #2 resetn = 1'b0;
        repeat (3) @(posedge CLK);
        #1 resetn = 1'b1;
        @(posedge CLK); #1;
    endtask

    task automatic send(input logic d, input logic [63:0] v, input logic [63:0] a,
                        input logic [31:0] t);
        int k = 0;
        cmd_if.cmd_dir = d; cmd_if.cmd_velocity = v; cmd_if.cmd_accel = a;
        cmd_if.cmd_ticks = t; cmd_if.cmd_valid = 1'b1;
        while (!cmd_if.cmd_ready && k < 5000) begin
            @(posedge CLK); #1; k++;
        end
        if (k >= 5000) begin
            total++; bad++;
            $display("FAIL send_timeout: got ready=0 want ready=1");
        end
        @(posedge CLK); #1;
        cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int target, input string nm);
        int k = 0;
        while (!(n_dones >= target && !enable) && k < 8000) begin
            @(posedge CLK); #1; k++;
        end
        if (k >= 8000) begin
            total++; bad++;
            $display("FAIL %s_timeout: got dones=%0d want %0d", nm, n_dones, target);
        end
    endtask

    // Reference: walk the ticks with plain wide arithmetic, counting accumulator wraps.
    logic [63:0] m_acc;
    function automatic int model_steps(input logic [63:0] v, input logic [63:0] a,
                                       input logic [31:0] t);
        logic [64:0]        s;
        logic signed [66:0] vs;
        int                 c = 0;
        logic [63:0]        vel = v;
        for (int unsigned i = 0; i < t; i++) begin
            s = {1'b0, m_acc} + {1'b0, vel};
            if (s >= 65'h1_0000_0000_0000_0000) c++;
            m_acc = s[63:0];
            vs = $signed({3'b000, vel}) + $signed({{3{a[63]}}, a});
            if (vs < 0)                                 vel = 64'd0;
            else if (vs > 67'sh0_FFFF_FFFF_FFFF_FFFF)   vel = '1;
            else                                        vel = vs[63:0];
        end
        return c;
    endfunction

    typedef struct {
        string       nm;
        logic        d;
        logic [63:0] v;
        logic [63:0] a;
        logic [31:0] t;
        logic [7:0]  div;
        int          exp_steps;
        logic        exp_ovr;
        logic        exp_dir;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int bs, bd, k;
        logic [63:0] neg32;
        neg32 = 64'hFFFF_FFFF_FFFF_FFE0;

        tbl[0] = '{"slow_half",  1'b0, HALF, 64'd0, 32'd10, 8'd15, 5, 1'b0, 1'b0};
        tbl[1] = '{"fast_half",  1'b0, HALF, 64'd0, 32'd10, 8'd0,  1, 1'b1, 1'b0};
        tbl[2] = '{"zero_ticks", 1'b0, HALF, 64'd0, 32'd0,  8'd9,  0, 1'b0, 1'b0};
        tbl[3] = '{"clamp_max",  1'b0, 64'hFFFF_FFFF_FFFF_FFF0, 64'd32, 32'd6, 8'd9, 5, 1'b0, 1'b0};
        tbl[4] = '{"clamp_zero", 1'b0, 64'd16, neg32, 32'd6, 8'd9, 0, 1'b0, 1'b0};
        tbl[5] = '{"overrun",    1'b0, HALF, 64'd1, 32'd8, 8'd3,  2, 1'b1, 1'b0};
        tbl[6] = '{"zero_dir1",  1'b1, HALF, 64'd0, 32'd0,  8'd9,  0, 1'b0, 1'b1};

        cmd_if.cmd_valid = 1'b0; cmd_if.cmd_dir = 1'b0; cmd_if.cmd_velocity = '0;
        cmd_if.cmd_accel = '0; cmd_if.cmd_ticks = '0;

        // Reset state
        do_reset();
        check("rst_step", {63'd0, step}, 64'd0);
        check("rst_dir", {63'd0, dir}, 64'd0);
        check("rst_enable", {63'd0, enable}, 64'd0);
        check("rst_done", {63'd0, move_done}, 64'd0);
        check("rst_ovr", {63'd0, step_overrun}, 64'd0);
        check("rst_ready", {63'd0, cmd_if.cmd_ready}, 64'd1);

        // Directed vector table, one move per entry from reset
        for (int i = 0; i < 7; i++) begin
            do_reset();
            clock_divisor = tbl[i].div;
            bs = n_steps; bd = n_dones;
            send(tbl[i].d, tbl[i].v, tbl[i].a, tbl[i].t);
            wait_done(bd + 1, tbl[i].nm);
            repeat (12) @(posedge CLK);
            #1;
            check({tbl[i].nm, "_steps"}, 64'(n_steps - bs), 64'(tbl[i].exp_steps));
            check({tbl[i].nm, "_dones"}, 64'(n_dones - bd), 64'd1);
            check({tbl[i].nm, "_ovr"}, {63'd0, step_overrun}, {63'd0, tbl[i].exp_ovr});
            check({tbl[i].nm, "_dir"}, {63'd0, dir}, {63'd0, tbl[i].exp_dir});
            check({tbl[i].nm, "_enable"}, {63'd0, enable}, 64'd0);
        end

        // Zero-length move: done exactly two edges after the accept edge, one cycle wide
        do_reset();
        clock_divisor = 8'd0;
        bs = n_steps;
        send(1'b0, HALF, 64'd0, 32'd0);
        k = 0;
        while (!move_done && k < 20) begin
            @(posedge CLK); #1; k++;
        end
        check("zero_latency", 64'(k), 64'd2);
        @(posedge CLK); #1;
        check("zero_done_width", {63'd0, move_done}, 64'd0);
        check("zero_ready", {63'd0, cmd_if.cmd_ready}, 64'd1);
        check("zero_nostep", 64'(n_steps - bs), 64'd0);

        // Queued move with direction reversal
        do_reset();
        clock_divisor = 8'd9;
        bs = n_steps; bd = n_dones;
        send(1'b0, HALF, 64'd0, 32'd4);
        send(1'b1, HALF, 64'd0, 32'd4);
        wait_done(bd + 2, "rev");
        repeat (12) @(posedge CLK);
        #1;
        check("rev_steps", 64'(n_steps - bs), 64'd4);
        check("rev_dones", 64'(n_dones - bd), 64'd2);
        check("rev_dir", {63'd0, dir}, 64'd1);

        // Halt mid-move with a pending command
        do_reset();
        clock_divisor = 8'd9;
        bd = n_dones;
        send(1'b0, HALF, 64'd0, 32'd1000);
        send(1'b1, HALF, 64'd0, 32'd100);
        k = 0;
        while (!step && k < 3000) begin
            @(posedge CLK); #1; k++;
        end
        check("halt_saw_step", {63'd0, step}, 64'd1);
        halt = 1'b1;
        @(posedge CLK); #1;
        halt = 1'b0;
        check("halt_ready", {63'd0, cmd_if.cmd_ready}, 64'd1);
        check("halt_pulse_held", {63'd0, step}, 64'd1);
        repeat (12) @(posedge CLK);
        #1;
        check("halt_enable", {63'd0, enable}, 64'd0);
        bs = n_steps;
        repeat (100) @(posedge CLK);
        #1;
        check("halt_nodone", 64'(n_dones - bd), 64'd0);
        check("halt_flushed", 64'(n_steps - bs), 64'd0);
        check("halt_dir", {63'd0, dir}, 64'd0);

        // Asynchronous reset in the middle of a pulse
        do_reset();
        clock_divisor = 8'd9;
        send(1'b0, HALF, 64'd0, 32'd100);
        k = 0;
        while (!step && k < 3000) begin
            @(posedge CLK); #1; k++;
        end
        #2 resetn = 1'b0;
        #1;
        check("areset_step", {63'd0, step}, 64'd0);
        check("areset_enable", {63'd0, enable}, 64'd0);
        check("areset_ready", {63'd0, cmd_if.cmd_ready}, 64'd1);

        // Randomized move streams against the reference model
        do_reset();
        m_acc = '0;
        for (int r = 0; r < 3; r++) begin
            int          exp_s;
            logic        last_d;
            logic [63:0] rv, ra;
            logic [31:0] rt;
            clock_divisor = 8'($urandom_range(9, 12));
            bs = n_steps; bd = n_dones; exp_s = 0; last_d = dir;
            for (int m = 0; m < 6; m++) begin
                last_d = 1'($urandom_range(0, 1));
                rv = {$urandom, $urandom};
                ra = {$urandom, $urandom};
                ra = $signed(ra) >>> $urandom_range(20, 63);
                rt = 32'($urandom_range(0, 15));
                exp_s += model_steps(rv, ra, rt);
                send(last_d, rv, ra, rt);
            end
            wait_done(bd + 6, "rand");
            repeat (12) @(posedge CLK);
            #1;
            check("rand_steps", 64'(n_steps - bs), 64'(exp_s));
            check("rand_dones", 64'(n_dones - bd), 64'd6);
            check("rand_dir", {63'd0, dir}, {63'd0, last_d});
            check("rand_ovr", {63'd0, step_overrun}, 64'd0);
        end

        check("setup_violations", 64'(n_setup_viol), 64'd0);
        check("width_violations", 64'(n_width_viol), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
